fc_layer: RTL
=============

FC_LAYER -- requirements
Module: fc_layer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, signed fixed-point word width.
- ADDR_WIDTH, 18, DRAM word-address width.
- FRAC_BITS, 16, fractional bits of every operand.
- MAX_IN, 512, input-vector capacity, sets on-chip buffer depth.
- MAX_OUT, 128, output-vector capacity.
REQ-002 Ports, one per line: name, direction, width, meaning. CW = clog2(MAX_IN+1); OW = clog2(MAX_OUT+1).
- clk, in, 1, clock.
- srstn, in, 1, reset; synchronous, active-low.
- start, in, 1, start pulse; sampled in IDLE only.
- cfg_num_in, in, CW, input length N.
- cfg_num_out, in, OW, output length M.
- cfg_relu, in, 1, 1 = apply ReLU.
- cfg_if_base / cfg_wt_base / cfg_bs_base / cfg_of_base, in, ADDR_WIDTH each, region base addresses.
- rd_req, out, 1, read request.
- rd_addr, out, ADDR_WIDTH, read address.
- rd_valid, in, 1, read data valid, read accepted.
- rd_data, in, DATA_WIDTH, read data.
- wr_en, out, 1, write strobe, one word per cycle.
- wr_addr, out, ADDR_WIDTH, write address.
- wr_data, out, DATA_WIDTH, write data.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle pulse with done on a bad configuration.

Function
REQ-003 FSM states: IDLE, LD_IF, MAC, BIAS, WR, DONE.
REQ-004 IDLE: start=1 latches all cfg_* inputs; cfg changes after that point are ignored until the next start.
- N=0, M=0, N>MAX_IN or M>MAX_OUT: go to DONE; done=1 and err=1; no reads, no writes.
- Otherwise go to LD_IF.
REQ-005 Read handshake: only one read outstanding at a time.
- rd_req and rd_addr are held stable until the cycle rd_valid=1.
- rd_data is captured in that cycle.
- The next request may start on the following cycle.
- rd_valid while rd_req=0 is ignored.
REQ-006 LD_IF: reads if_base+i for i=0..N-1 into buffer entry i, then goes to MAC with o=0.
REQ-007 MAC, for output o: reads wt_base+o*N+i for i=0..N-1.
- Each captured weight is multiplied by buffer[i] as a full 2*DATA_WIDTH signed product.
- The product is arithmetically shifted right by FRAC_BITS.
- The shifted result is sign-extended into a DATA_WIDTH+8 accumulator.
- The accumulator is cleared on entry to MAC.
- After the last weight, go to BIAS.
REQ-008 BIAS: reads bs_base+o and adds it (sign-extended) to the accumulator.
- Saturate the sum to the signed DATA_WIDTH range.
- If cfg_relu=1, negative results become 0.
- Go to WR.
REQ-009 WR: one cycle with wr_en=1, wr_addr=of_base+o, wr_data = the result from REQ-008.
- o<M-1: o increments and FSM returns to MAC.
- o=M-1: go to DONE.
REQ-010 DONE: done=1 for exactly one cycle, then IDLE; err=0 except for the REQ-004 error case.
REQ-011 Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
REQ-012 The multiply/accumulate may be pipelined internally.
- wr_data must include every product of output o.
- The write happens at most 3 cycles after the bias read is accepted.
REQ-013 A start received while busy=1 is ignored.
REQ-014 Write ordering: no write is issued while rd_req=1; wr_en never overlaps rd_req.

Reset
REQ-015 srstn=0 at a clock edge (including mid-operation) forces IDLE.
- rd_req, wr_en, busy, done and err are 0.
- rd_addr, wr_addr and wr_data are 0.
- Accumulator and counters are cleared.
REQ-016 Buffer contents are not required to reset; the first buffer read of any run must be preceded by that run's own LD_IF write.

Verification
REQ-017 N=2, M=1, FRAC_BITS=16, zero-wait DRAM.
- Stimulus: in = {2.0, 3.0} (0x20000, 0x30000), w = {1.0, -1.0}, bias 0.5, relu=0.
- Response: one write, data 0xFFFF8000 (-0.5), at of_base.
- Same run with relu=1 -> data 0.
REQ-018 Random rd_valid delays of 0-5 cycles, N=400, M=120, with the same values as a zero-wait run.
- Response: identical wr_addr/wr_data sequence.
- rd_addr is stable during every wait.
REQ-019 Saturation: N=4, all inputs and weights 0x7FFF0000, bias 0x7FFFFFFF.
- Response: wr_data = 0x7FFFFFFF.
- Negating the weights gives 0x80000000 with relu=0.
REQ-020 start with N=0, and separately with M=MAX_OUT+1.
- Response: done=err=1 within 2 cycles; zero rd_req cycles; zero wr_en cycles.
REQ-021 srstn=0 in the middle of MAC of output 5, then restart with N=2, M=1.
- Response: outputs at reset values on the next cycle.
- The restarted run produces the REQ-017 result.
REQ-022 start pulsed during MAC.
- Response: no effect on the write sequence; exactly one done.

Source files
------------

// File: rtl/fc_layer.sv
// Fully-connected layer engine: streams an input vector from DRAM into an
// on-chip buffer, then for each output neuron streams its weight row,
// accumulates fixed-point products, adds the bias, saturates, optionally
// applies ReLU and writes one result word back to DRAM.
//
// Read handshake: rd_req/rd_addr are held until the cycle rd_valid=1; that
// cycle accepts the word on rd_data. A new request may appear the very next
// cycle. rd_valid while rd_req=0 has no effect. At most one read is in
// flight and wr_en is never asserted while rd_req=1.
module fc_layer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int FRAC_BITS  = 16,
    parameter int MAX_IN     = 512,
    parameter int MAX_OUT    = 128,
    localparam int CW = $clog2(MAX_IN + 1),
    localparam int OW = $clog2(MAX_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start,
    input  logic [CW-1:0]         cfg_num_in,
    input  logic [OW-1:0]         cfg_num_out,
    input  logic                  cfg_relu,
    input  logic [ADDR_WIDTH-1:0] cfg_if_base,
    input  logic [ADDR_WIDTH-1:0] cfg_wt_base,
    input  logic [ADDR_WIDTH-1:0] cfg_bs_base,
    input  logic [ADDR_WIDTH-1:0] cfg_of_base,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BW    = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
    localparam int ACC_W = DATA_WIDTH + 8;
    localparam int PW    = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_IF = 3'd1,
        MAC   = 3'd2,
        BIAS  = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Current FSM state; kept as a named enum so checkers can bind to it.
    state_t state;

    // Configuration latched at start.
    logic [CW-1:0]         n_r;
    logic [OW-1:0]         m_r;
    logic                  relu_r;
    logic [ADDR_WIDTH-1:0] bs_base_r;
    logic [ADDR_WIDTH-1:0] of_base_r;

    // Counters and datapath state.
    logic [CW-1:0]            idx;
    logic [OW-1:0]            o_cnt;
    logic [ADDR_WIDTH-1:0]    wt_ptr;
    logic signed [ACC_W-1:0]  acc;

    // Input-vector buffer; no reset so it can map onto RAM.
    logic [DATA_WIDTH-1:0] if_buf [0:MAX_IN-1];
    logic [BW-1:0]         buf_idx;

    logic                    accept;
    logic                    cfg_bad;
    logic signed [PW-1:0]    w_ext;
    logic signed [PW-1:0]    x_ext;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_sh;
    logic signed [PW:0]      mac_sum;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W:0]   bias_sum;
    logic [DATA_WIDTH-1:0]   bias_res;

    localparam logic signed [PW:0] ACC_MAX =
        {{(PW + 2 - ACC_W){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [PW:0] ACC_MIN =
        {{(PW + 2 - ACC_W){1'b1}}, {(ACC_W - 1){1'b0}}};
    localparam logic signed [ACC_W:0] DAT_MAX =
        {{(ACC_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] DAT_MIN =
        {{(ACC_W + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    assign accept  = rd_req & rd_valid;
    assign buf_idx = idx[BW-1:0];

    // A zero-length or oversized job is rejected without touching memory.
    assign cfg_bad = (cfg_num_in == '0) || (cfg_num_out == '0) ||
                     (32'(cfg_num_in) > 32'(MAX_IN)) ||
                     (32'(cfg_num_out) > 32'(MAX_OUT));

    // Multiply-accumulate and bias/saturate/ReLU datapath on the captured word.
    always_comb begin
        w_ext    = {{DATA_WIDTH{rd_data[DATA_WIDTH-1]}}, rd_data};
        x_ext    = {{DATA_WIDTH{if_buf[buf_idx][DATA_WIDTH-1]}}, if_buf[buf_idx]};
        prod     = w_ext * x_ext;
        prod_sh  = prod >>> FRAC_BITS;
        mac_sum  = {{(PW + 1 - ACC_W){acc[ACC_W-1]}}, acc} + {prod_sh[PW-1], prod_sh};
        // The accumulator clamps instead of wrapping so that huge products
        // still drive the final result to the correct saturation rail.
        if (mac_sum > ACC_MAX) begin
            acc_next = {1'b0, {(ACC_W - 1){1'b1}}};
        end else if (mac_sum < ACC_MIN) begin
            acc_next = {1'b1, {(ACC_W - 1){1'b0}}};
        end else begin
            acc_next = mac_sum[ACC_W-1:0];
        end

        bias_sum = {acc[ACC_W-1], acc} +
                   {{(ACC_W + 1 - DATA_WIDTH){rd_data[DATA_WIDTH-1]}}, rd_data};
        if (bias_sum > DAT_MAX) begin
            bias_res = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (bias_sum < DAT_MIN) begin
            bias_res = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            bias_res = bias_sum[DATA_WIDTH-1:0];
        end
        if (relu_r && bias_res[DATA_WIDTH-1]) begin
            bias_res = '0;
        end
    end

    // Buffer fill: each accepted input word lands at its element index.
    always_ff @(posedge clk) begin
        if (state == LD_IF && accept) begin
            if_buf[buf_idx] <= rd_data;
        end
    end

    // Control FSM with registered DRAM and status outputs.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state     <= IDLE;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            o_cnt     <= '0;
            wt_ptr    <= '0;
            n_r       <= '0;
            m_r       <= '0;
            relu_r    <= 1'b0;
            bs_base_r <= '0;
            of_base_r <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r       <= cfg_num_in;
                        m_r       <= cfg_num_out;
                        relu_r    <= cfg_relu;
                        bs_base_r <= cfg_bs_base;
                        of_base_r <= cfg_of_base;
                        wt_ptr    <= cfg_wt_base;
                        idx       <= '0;
                        o_cnt     <= '0;
                        acc       <= '0;
                        busy      <= 1'b1;
                        if (cfg_bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= LD_IF;
                            rd_req  <= 1'b1;
                            rd_addr <= cfg_if_base;
                        end
                    end
                end
                LD_IF: begin
                    if (accept) begin
                        if (idx == n_r - 1'b1) begin
                            state   <= MAC;
                            idx     <= '0;
                            acc     <= '0;
                            o_cnt   <= '0;
                            rd_addr <= wt_ptr;
                        end else begin
                            idx     <= idx + 1'b1;
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                MAC: begin
                    // Weight rows are contiguous, so the pointer simply runs on
                    // from one output to the next.
                    if (accept) begin
                        acc <= acc_next;
                        if (idx == n_r - 1'b1) begin
                            state   <= BIAS;
                            idx     <= '0;
                            wt_ptr  <= rd_addr + 1'b1;
                            rd_addr <= bs_base_r + ADDR_WIDTH'(o_cnt);
                        end else begin
                            idx     <= idx + 1'b1;
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    if (accept) begin
                        state   <= WR;
                        rd_req  <= 1'b0;
                        wr_en   <= 1'b1;
                        wr_addr <= of_base_r + ADDR_WIDTH'(o_cnt);
                        wr_data <= bias_res;
                    end
                end
                WR: begin
                    if (o_cnt == m_r - 1'b1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= MAC;
                        o_cnt   <= o_cnt + 1'b1;
                        acc     <= '0;
                        idx     <= '0;
                        rd_req  <= 1'b1;
                        rd_addr <= wt_ptr;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
